commit_agg_table: RTL

// - Parametrised commit aggregator between MPU issue and the TPU array.
// - Per issued instruction, records issue number and enabled-TPU mask; collects per-TPU commits.
// - Emits one aggregated commit to the MPU once every enabled TPU has committed.
// - Extends fixed-size aggregation with: DEPTH-entry table, any TPU count,

---
 rtl/commit_agg_table_if.sv | 29 ++
 rtl/commit_agg_table.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/commit_agg_table_if.sv
// Handshake bundle between the MPU/TPU side and the commit aggregation table.
// Signal names match the original flat port list so existing hookups map one-to-one.
interface commit_agg_table_if #(
    parameter int NUM_TPU = 4,
    parameter int DEPTH   = 4,
    parameter int ISSUE_W = 8
);
    logic                         I_Issue_Valid;
    logic [ISSUE_W-1:0]           I_Issue_No;
    logic [NUM_TPU-1:0]           I_En_TPU;
    logic                         O_Issue_Ready;
    logic [NUM_TPU-1:0]           I_Commit;
    logic [NUM_TPU*ISSUE_W-1:0]   I_Commit_No;
    logic                         O_Commit_Valid;
    logic [ISSUE_W-1:0]           O_Commit_No;
    logic                         I_Commit_Ack;
    logic [$clog2(DEPTH+1)-1:0]   O_Count;
    logic                         O_Err;

    modport master (
        output I_Issue_Valid, I_Issue_No, I_En_TPU, I_Commit, I_Commit_No, I_Commit_Ack,
        input  O_Issue_Ready, O_Commit_Valid, O_Commit_No, O_Count, O_Err
    );

    modport slave (
        input  I_Issue_Valid, I_Issue_No, I_En_TPU, I_Commit, I_Commit_No, I_Commit_Ack,
        output O_Issue_Ready, O_Commit_Valid, O_Commit_No, O_Count, O_Err
    );
endinterface

// File: rtl/commit_agg_table.sv
// Commit aggregator: tracks issued instructions, collects per-TPU commits and
// hands one aggregated commit per instruction back to the MPU over valid/ack.
module commit_agg_table #(
    parameter int NUM_TPU  = 4,
    parameter int DEPTH    = 4,
    parameter int ISSUE_W  = 8,
    parameter int IN_ORDER = 1
) (
    input  logic               clock,
    input  logic               reset,
    commit_agg_table_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]   v;
    logic [DEPTH-1:0]   sel;
    logic [ISSUE_W-1:0] issue_no [DEPTH];
    logic [NUM_TPU-1:0] en_tpu   [DEPTH];
    logic [NUM_TPU-1:0] commit   [DEPTH];

    logic [PW-1:0]      head;
    logic [PW-1:0]      tail;
    logic [CW-1:0]      count;
    logic               out_valid;
    logic [ISSUE_W-1:0] out_no;
    logic [PW-1:0]      out_idx;
    logic               err;

    logic               alloc;
    logic [PW-1:0]      alloc_idx;
    logic               alloc_found;
    logic               load;
    logic               free;
    logic [DEPTH-1:0]   complete;
    logic               cand_valid;
    logic [PW-1:0]      cand_idx;
    logic [NUM_TPU-1:0] commit_set [DEPTH];
    logic [NUM_TPU-1:0] err_vec;
    logic               m_found;
    logic [PW-1:0]      m_idx;
    logic [PW-1:0]      probe;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign alloc = bus.I_Issue_Valid & (count != CW'(DEPTH));
    assign free  = out_valid & bus.I_Commit_Ack;
    assign load  = ~out_valid & cand_valid;

    assign bus.O_Issue_Ready  = (count != CW'(DEPTH));
    assign bus.O_Commit_Valid = out_valid;
    assign bus.O_Commit_No    = out_no;
    assign bus.O_Count        = count;
    assign bus.O_Err          = err;

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++)
            complete[i] = v[i] & ~sel[i] & ((commit[i] & en_tpu[i]) == en_tpu[i]);
    end

    always_comb begin
        alloc_idx   = tail;
        alloc_found = 1'b0;
        if (IN_ORDER == 0) begin
            alloc_idx = '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (!alloc_found && !v[i]) begin
                    alloc_found = 1'b1;
                    alloc_idx   = PW'(i);
                end
            end
        end
    end

    always_comb begin
        cand_valid = 1'b0;
        cand_idx   = head;
        if (IN_ORDER != 0) begin
            cand_valid = complete[head];
        end else begin
            cand_idx = '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (!cand_valid && complete[i]) begin
                    cand_valid = 1'b1;
                    cand_idx   = PW'(i);
                end
            end
        end
    end

    // Each TPU lane searches independently, oldest first; a hit on an already
    // committed lane is a duplicate and must not fall through to a younger entry.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++)
            commit_set[i] = '0;
        err_vec = '0;
        m_found = 1'b0;
        m_idx   = '0;
        probe   = '0;
        for (int unsigned t = 0; t < NUM_TPU; t++) begin
            m_found = 1'b0;
            m_idx   = '0;
            if (bus.I_Commit[t]) begin
                for (int unsigned k = 0; k < DEPTH; k++) begin
                    probe = (IN_ORDER != 0) ? PW'((32'(head) + k) % DEPTH) : PW'(k);
                    if (!m_found && v[probe] && en_tpu[probe][t] &&
                        issue_no[probe] == bus.I_Commit_No[t*ISSUE_W +: ISSUE_W]) begin
                        m_found = 1'b1;
                        m_idx   = probe;
                    end
                end
                if (!m_found || commit[m_idx][t])
                    err_vec[t] = 1'b1;
                else
                    commit_set[m_idx][t] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            v         <= '0;
            sel       <= '0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_no    <= '0;
            out_idx   <= '0;
            err       <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                issue_no[i] <= '0;
                en_tpu[i]   <= '0;
                commit[i]   <= '0;
            end
        end else begin
            err <= |err_vec;
            for (int unsigned i = 0; i < DEPTH; i++)
                commit[i] <= commit[i] | commit_set[i];
            if (alloc) begin
                v[alloc_idx]        <= 1'b1;
                sel[alloc_idx]      <= 1'b0;
                issue_no[alloc_idx] <= bus.I_Issue_No;
                en_tpu[alloc_idx]   <= bus.I_En_TPU;
                commit[alloc_idx]   <= '0;
                if (IN_ORDER != 0)
                    tail <= ptr_inc(tail);
            end
            if (load) begin
                sel[cand_idx] <= 1'b1;
                out_valid     <= 1'b1;
                out_no        <= issue_no[cand_idx];
                out_idx       <= cand_idx;
            end
            if (free) begin
                v[out_idx]   <= 1'b0;
                sel[out_idx] <= 1'b0;
                out_valid    <= 1'b0;
                if (IN_ORDER != 0)
                    head <= ptr_inc(head);
            end
            count <= count + CW'(alloc) - CW'(free);
        end
    end
endmodule
